// File: rtl/raisin64_ex_pkg.sv
// Shared encodings for the Raisin64 execute ALU: unit codes, per-unit op codes
// and flag bit positions within {Z,N,C,V}.
package raisin64_ex_pkg;

  typedef enum logic [2:0] {
    ALU_U_ADD = 3'd0,
    ALU_U_LOG = 3'd1,
    ALU_U_SHF = 3'd2,
    ALU_U_MOV = 3'd3
  } alu_unit_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_SLT  = 2'd2,
    OP_SLTU = 2'd3
  } add_op_e;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } log_op_e;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ROR = 2'd3
  } shf_op_e;

  typedef enum logic [1:0] {
    OP_MV1 = 2'd0,
    OP_MV2 = 2'd1,
    OP_MZ2 = 2'd2,
    OP_MZ3 = 2'd3
  } mov_op_e;

  localparam int FLAG_W = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/ex_alu_pipe_core.sv
// Combinational XLEN-wide ALU datapath feeding stage 1 of ex_alu_pipe.
// Flag generation is built only when EX_ALU_FLAGS_EN is defined.
module ex_alu_pipe_core
  import raisin64_ex_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]   in1,
  input  logic [XLEN-1:0]   in2,
  input  logic [2:0]        unit,
  input  logic [1:0]        op,
  output logic [XLEN-1:0]   res
`ifdef EX_ALU_FLAGS_EN
  ,
  output logic [FLAG_W-1:0] flags
`endif
);

  localparam int SH_W = $clog2(XLEN);
  // One extra adder bit exposes carry / ~borrow when flags are wanted.
`ifdef EX_ALU_FLAGS_EN
  localparam int AW = XLEN + 1;
`else
  localparam int AW = XLEN;
`endif

  logic [AW-1:0]   sum_s;
  logic [AW-1:0]   dif_s;
  logic [SH_W-1:0] shamt_s;
  logic [XLEN-1:0] ror_s;

  assign sum_s   = AW'(in1) + AW'(in2);
  assign dif_s   = AW'(in1) + AW'(~in2) + AW'(1);
  assign shamt_s = in2[SH_W-1:0];
  assign ror_s   = (in1 >> shamt_s) | (in1 << (SH_W+1)'(XLEN - int'(shamt_s)));

  always_comb begin
    res = '0;
    case (unit)
      ALU_U_ADD: begin
        case (op)
          OP_ADD:  res = sum_s[XLEN-1:0];
          OP_SUB:  res = dif_s[XLEN-1:0];
          OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
          OP_SLTU: res = {{(XLEN-1){1'b0}}, (in1 < in2)};
          default: res = '0;
        endcase
      end
      ALU_U_LOG: begin
        case (op)
          OP_AND:  res = in1 & in2;
          OP_OR:   res = in1 | in2;
          OP_XOR:  res = in1 ^ in2;
          OP_NOR:  res = ~(in1 | in2);
          default: res = '0;
        endcase
      end
      ALU_U_SHF: begin
        case (op)
          OP_SLL:  res = in1 << shamt_s;
          OP_SRL:  res = in1 >> shamt_s;
          OP_SRA:  res = XLEN'($signed(in1) >>> shamt_s);
          OP_ROR:  res = ror_s;
          default: res = '0;
        endcase
      end
      ALU_U_MOV: begin
        case (op)
          OP_MV1:  res = in1;
          OP_MV2:  res = in2;
          default: res = '0;
        endcase
      end
      default: res = '0;
    endcase
  end

`ifdef EX_ALU_FLAGS_EN
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_N] = res[XLEN-1];
    if (unit == ALU_U_ADD && op == OP_ADD) begin
      flags[FLAG_C] = sum_s[XLEN];
      flags[FLAG_V] = (in1[XLEN-1] == in2[XLEN-1]) && (sum_s[XLEN-1] != in1[XLEN-1]);
    end else if (unit == ALU_U_ADD && op == OP_SUB) begin
      flags[FLAG_C] = dif_s[XLEN];
      flags[FLAG_V] = (in1[XLEN-1] != in2[XLEN-1]) && (dif_s[XLEN-1] != in1[XLEN-1]);
    end else begin
      flags[FLAG_C] = 1'b0;
      flags[FLAG_V] = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/ex_alu_pipe.sv
// Raisin64 execute ALU: valid/ready pipeline of STAGES registers with flush.
// Define EX_ALU_FLAGS_EN to add the registered {Z,N,C,V} out_flags port.
module ex_alu_pipe
  import raisin64_ex_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int RN_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in1,
  input  logic [XLEN-1:0]   in2,
  input  logic [2:0]        unit,
  input  logic [1:0]        op,
  input  logic [RN_W-1:0]   rd_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out,
  output logic [RN_W-1:0]   rd_out
`ifdef EX_ALU_FLAGS_EN
  ,
  output logic [FLAG_W-1:0] out_flags
`endif
);

  logic [XLEN-1:0]   core_res_s;
  logic [STAGES-1:0] v_q, v_d, adv_s;
  logic [XLEN-1:0]   res_q [STAGES];
  logic [XLEN-1:0]   res_d [STAGES];
  logic [RN_W-1:0]   rd_q  [STAGES];
  logic [RN_W-1:0]   rd_d  [STAGES];
  logic              rdy_en_q, rdy_en_d;
  logic              in_ready_s;
`ifdef EX_ALU_FLAGS_EN
  logic [FLAG_W-1:0] core_fl_s;
  logic [FLAG_W-1:0] fl_q [STAGES];
  logic [FLAG_W-1:0] fl_d [STAGES];
`endif

  ex_alu_pipe_core #(.XLEN(XLEN)) u_core (
    .in1   (in1),
    .in2   (in2),
    .unit  (unit),
    .op    (op),
    .res   (core_res_s)
`ifdef EX_ALU_FLAGS_EN
    ,
    .flags (core_fl_s)
`endif
  );

  // Ready ripples back from the output; each stage then loads from the one before.
  always_comb begin : p_pipe
    logic              nxt_open;
    logic              ld;
    logic [XLEN-1:0]   src_res;
    logic [RN_W-1:0]   src_rd;
`ifdef EX_ALU_FLAGS_EN
    logic [FLAG_W-1:0] src_fl;
    fl_d   = fl_q;
    src_fl = core_fl_s;
`endif
    adv_s    = '0;
    v_d      = v_q;
    res_d    = res_q;
    rd_d     = rd_q;
    rdy_en_d = 1'b1;
    nxt_open = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv_s[k] = v_q[k] & nxt_open & ~flush;
      nxt_open = ~v_q[k] | adv_s[k];
    end
    in_ready_s = rdy_en_q & ~flush & nxt_open;
    ld         = in_valid & in_ready_s;
    src_res    = core_res_s;
    src_rd     = rd_in;
    for (int k = 0; k < STAGES; k++) begin
      if (flush)          v_d[k] = 1'b0;
      else if (ld)        v_d[k] = 1'b1;
      else if (adv_s[k])  v_d[k] = 1'b0;
      else                v_d[k] = v_q[k];
      if (ld) begin
        res_d[k] = src_res;
        rd_d[k]  = src_rd;
`ifdef EX_ALU_FLAGS_EN
        fl_d[k]  = src_fl;
`endif
      end else begin
        res_d[k] = res_q[k];
        rd_d[k]  = rd_q[k];
`ifdef EX_ALU_FLAGS_EN
        fl_d[k]  = fl_q[k];
`endif
      end
      ld      = adv_s[k];
      src_res = res_q[k];
      src_rd  = rd_q[k];
`ifdef EX_ALU_FLAGS_EN
      src_fl  = fl_q[k];
`endif
    end
  end

  // in_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= rdy_en_d;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    // Stage g valid + payload register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q[g]   <= 1'b0;
        res_q[g] <= '0;
        rd_q[g]  <= '0;
`ifdef EX_ALU_FLAGS_EN
        fl_q[g]  <= '0;
`endif
      end else begin
        v_q[g]   <= v_d[g];
        res_q[g] <= res_d[g];
        rd_q[g]  <= rd_d[g];
`ifdef EX_ALU_FLAGS_EN
        fl_q[g]  <= fl_d[g];
`endif
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = v_q[STAGES-1];
  assign out       = res_q[STAGES-1];
  assign rd_out    = rd_q[STAGES-1];
`ifdef EX_ALU_FLAGS_EN
  assign out_flags = fl_q[STAGES-1];
`endif

endmodule

// File: tb/tb_ex_alu_pipe.sv
// Self-checking bench for ex_alu_pipe: directed table, handshake corner cases,
// and randomized traffic against a behavioural scoreboard model.
module tb_ex_alu_pipe;

  localparam int XLEN   = 64;
  localparam int STAGES = 2;
  localparam int RN_W   = 6;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0]     in1, in2, out;
  logic [2:0]      unit;
  logic [1:0]      op;
  logic [5:0]      rd_in, rd_out;
`ifdef EX_ALU_FLAGS_EN
  logic [3:0]      out_flags;
`endif

  ex_alu_pipe #(.XLEN(XLEN), .STAGES(STAGES), .RN_W(RN_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .unit(unit), .op(op), .rd_in(rd_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .rd_out(rd_out)
`ifdef EX_ALU_FLAGS_EN
    , .out_flags(out_flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  unit;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [5:0]  rd;
    logic [63:0] res;
    logic [3:0]  fl;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic [5:0]  rd;
    logic [3:0]  fl;
    int          acc;
  } exp_t;

  vec_t        tbl [15];
  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          check_lat = 1'b0;
  bit          hold_prev = 1'b0;
  logic [63:0] prev_out;
  logic [5:0]  prev_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model straight from the function table.
  function automatic void ref_calc(input logic [2:0] u, input logic [1:0] o,
                                   input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] r, output logic [3:0] f);
    int          sh;
    logic [64:0] sa, sbv, t;
    bit          c, v;
    sh = int'(b[5:0]);
    r = 64'd0; c = 1'b0; v = 1'b0;
    sa  = {a[63], a};
    sbv = {b[63], b};
    case (u)
      3'd0: case (o)
        2'd0: begin r = a + b; c = ({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF;
                    t = sa + sbv; v = (t[64] != t[63]); end
        2'd1: begin r = a - b; c = (a >= b); t = sa - sbv; v = (t[64] != t[63]); end
        2'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        default: r = (a < b) ? 64'd1 : 64'd0;
      endcase
      3'd1: case (o)
        2'd0: r = a & b;
        2'd1: r = a | b;
        2'd2: r = a ^ b;
        default: r = ~(a | b);
      endcase
      3'd2: case (o)
        2'd0: r = a << sh;
        2'd1: r = a >> sh;
        2'd2: begin r = a; for (int i = 0; i < sh; i++) r = {r[63], r[63:1]}; end
        default: begin r = a; for (int i = 0; i < sh; i++) r = {r[0], r[63:1]}; end
      endcase
      3'd3: r = (o == 2'd0) ? a : ((o == 2'd1) ? b : 64'd0);
      default: r = 64'd0;
    endcase
    f = {(r == 64'd0), r[63], c, v};
  endfunction

  // One clock: check outputs of this cycle, update scoreboard, advance to next negedge.
  task automatic cycle();
    exp_t        h, e;
    logic [63:0] r;
    logic [3:0]  f;
    #1;
    if (hold_prev && out_valid) begin
      chk("stable_out", out, prev_out);
      chk("stable_rd", 64'(rd_out), 64'(prev_rd));
    end
    if (out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out: got %h rd %0d, none expected (cycle %0d)", out, rd_out, cyc);
      end else begin
        h = sb.pop_front();
        chk("out", out, h.res);
        chk("rd_out", 64'(rd_out), 64'(h.rd));
`ifdef EX_ALU_FLAGS_EN
        chk("flags", 64'(out_flags), 64'(h.fl));
`endif
        if (check_lat) chk("latency", 64'(cyc - h.acc), 64'(STAGES));
      end
    end
    if (in_valid && in_ready) begin
      ref_calc(unit, op, in1, in2, r, f);
      e.res = r; e.rd = rd_in; e.fl = f; e.acc = cyc;
      sb.push_back(e);
    end
    if (flush) sb.delete();
    hold_prev = out_valid & ~out_ready & ~flush;
    prev_out  = out;
    prev_rd   = rd_out;
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_op(input logic [2:0] u, input logic [1:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] rd);
    unit = u; op = o; in1 = a; in2 = b; rd_in = rd;
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int w = 0; w < 20 && sb.size() > 0; w++) cycle();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{3'd0, 2'd0, 64'd5, 64'd7, 6'd3, 64'd12, 4'b0000};
    tbl[1]  = '{3'd0, 2'd1, 64'd0, 64'd1, 6'd4, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
    tbl[2]  = '{3'd2, 2'd2, 64'h8000_0000_0000_0000, 64'd63, 6'd5, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
    tbl[3]  = '{3'd2, 2'd3, 64'd1, 64'd1, 6'd6, 64'h8000_0000_0000_0000, 4'b0100};
    tbl[4]  = '{3'd2, 2'd0, 64'd1, 64'd64, 6'd7, 64'd1, 4'b0000};
    tbl[5]  = '{3'd0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd8, 64'h8000_0000_0000_0000, 4'b0101};
    tbl[6]  = '{3'd0, 2'd1, 64'd3, 64'd3, 6'd9, 64'd0, 4'b1010};
    tbl[7]  = '{3'd1, 2'd0, 64'hF0F0, 64'hFF00, 6'd10, 64'hF000, 4'b0000};
    tbl[8]  = '{3'd1, 2'd3, 64'd0, 64'd0, 6'd11, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
    tbl[9]  = '{3'd0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd12, 64'd1, 4'b0000};
    tbl[10] = '{3'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd13, 64'd0, 4'b1000};
    tbl[11] = '{3'd3, 2'd1, 64'd5, 64'h1234, 6'd14, 64'h1234, 4'b0000};
    tbl[12] = '{3'd5, 2'd1, 64'd9, 64'd9, 6'd15, 64'd0, 4'b1000};
    tbl[13] = '{3'd3, 2'd2, 64'd9, 64'd9, 6'd16, 64'd0, 4'b1000};
    tbl[14] = '{3'd2, 2'd1, 64'h8000_0000_0000_0000, 64'd4, 6'd17, 64'h0800_0000_0000_0000, 4'b0000};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_op(3'd0, 2'd0, 64'd0, 64'd0, 6'd0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", out, 64'd0);
    chk("rst_rd_out", 64'(rd_out), 64'd0);
`ifdef EX_ALU_FLAGS_EN
    chk("rst_flags", 64'(out_flags), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);

    // Streaming: ADD then SUB back-to-back
    check_lat = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; set_op(3'd0, 2'd0, 64'd5, 64'd7, 6'd3); cycle();
    set_op(3'd0, 2'd1, 64'd0, 64'd1, 6'd4); cycle();
    in_valid = 1'b0;
    chk("stream_v0", 64'(out_valid), 64'd1);
    chk("stream_out0", out, 64'd12);
    chk("stream_rd0", 64'(rd_out), 64'd3);
    cycle();
    chk("stream_v1", 64'(out_valid), 64'd1);
    chk("stream_out1", out, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("stream_rd1", 64'(rd_out), 64'd4);
    cycle();
    chk("stream_done", 64'(out_valid), 64'd0);

    // Table: one op at a time
    foreach (tbl[i]) begin
      bit got;
      set_op(tbl[i].unit, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd);
      in_valid = 1'b1; cycle(); in_valid = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        if (out_valid) begin
          chk($sformatf("tbl%0d_out", i), out, tbl[i].res);
          chk($sformatf("tbl%0d_rd", i), 64'(rd_out), 64'(tbl[i].rd));
`ifdef EX_ALU_FLAGS_EN
          chk($sformatf("tbl%0d_flags", i), 64'(out_flags), 64'(tbl[i].fl));
`endif
          got = 1'b1;
        end
        cycle();
      end
      if (!got) chk($sformatf("tbl%0d_timeout", i), 64'd0, 64'd1);
    end
    check_lat = 1'b0;

    // Backpressure: buffer fills after STAGES accepts
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(3'd0, 2'd0, 64'd100, 64'd1, 6'd20); cycle();
    set_op(3'd1, 2'd2, 64'hFF, 64'h0F, 6'd21); cycle();
    set_op(3'd3, 2'd0, 64'hABCD, 64'd0, 6'd22);
    #1 chk("full_in_ready", 64'(in_ready), 64'd0);
    cycle(); cycle();
    chk("full_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    cycle(); in_valid = 1'b0;
    drain();

    // Flush with two ops in flight and in_valid high
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(3'd0, 2'd0, 64'd1, 64'd1, 6'd30); cycle();
    set_op(3'd0, 2'd0, 64'd2, 64'd2, 6'd31); cycle();
    flush = 1'b1; set_op(3'd0, 2'd0, 64'd3, 64'd3, 6'd32);
    #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    for (int w = 0; w < 3; w++) begin
      cycle();
      chk("flush_stays_empty", 64'(out_valid), 64'd0);
    end

    // Reset mid-operation clears immediately
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(3'd1, 2'd1, 64'h55, 64'hAA, 6'd40); cycle(); cycle();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out", out, 64'd0);
    chk("midrst_rd", 64'(rd_out), 64'd0);
    sb.delete(); hold_prev = 1'b0;
    @(negedge clk); cyc++;
    rst_n = 1'b1;
    @(negedge clk); cyc++;
    chk("midrst_ready", 64'(in_ready), 64'd1);

    // Randomized traffic with backpressure and occasional flush
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      set_op(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), pick(), pick(),
             6'($urandom_range(0, 63)));
      cycle();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
